// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches instruction words from memory one request at
// a time into a small in-order buffer (FIFO_DEPTH entries), tagging every word
// with the address it came from. Branches flush the buffer and redirect the PC.
// A request already in flight when a branch arrives is drained and its data
// discarded.
//
// Optional build macro FETCH_TIMEOUT_EN: when defined, a watchdog counts the
// cycles spent waiting for mem_done. After TIMEOUT cycles it sets the sticky
// fetch_error flag and abandons the request. When undefined, there is no
// watchdog and fetch_error is tied low.
//
// Consumer handshake: instr_valid is high whenever the buffer holds an entry.
// The head entry (instr_out/instr_pc) leaves on a rising edge where both
// instr_valid and instr_ready are high. While instr_valid=1 and
// instr_ready=0, the head stays stable.
module instruction_fetch_unit #(
    parameter int PC_LIMIT   = 12,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] mem_address,
    output logic        mem_read,
    output logic        mem_instruction,
    input  logic [12:0] mem_dataOut,
    input  logic        mem_done,
    input  logic        branch_valid,
    input  logic [12:0] branch_target,
    output logic [12:0] instr_out,
    output logic [12:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_error,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [12:0] LIMIT = 13'(PC_LIMIT);
    localparam logic [2:0]  DEPTH = 3'(FIFO_DEPTH);
    localparam logic [1:0]  LAST  = 2'(FIFO_DEPTH - 1);

    state_t      state;
    state_t      state_next;
    logic [12:0] pc;
    logic [12:0] req_addr;
    logic [12:0] pc_inc;
    logic [12:0] target_clamped;
    logic        issue;
    logic        push;
    logic        pop;
    logic        flush;
    logic        timeout_hit;

    // Buffer storage. The arrays are always four entries deep, so pointers
    // are always 2 bits. Only the first FIFO_DEPTH entries are ever used.
    logic [12:0] data_q [0:3];
    logic [12:0] pc_q   [0:3];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign pc_inc         = (pc == LIMIT) ? 13'd0 : pc + 13'd1;
    assign target_clamped = (branch_target > LIMIT) ? 13'd0 : branch_target;

    assign instr_valid     = (count != 3'd0);
    assign instr_out       = instr_valid ? data_q[rd_ptr] : 13'd0;
    assign instr_pc        = instr_valid ? pc_q[rd_ptr] : 13'd0;
    assign pop             = instr_valid && instr_ready;
    assign mem_read        = (state != S_IDLE);
    assign mem_instruction = mem_read;
    assign mem_address     = req_addr;
    assign state_dbg       = state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and per-cycle control strobes. A branch has priority
    // over any push or pop in the same cycle.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            S_IDLE: begin
                if (branch_valid) begin
                    flush = 1'b1;
                end else if (count < DEPTH) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_valid) begin
                    // Data arriving with the branch is stale. Without data,
                    // the request is still open and has to be drained.
                    flush      = 1'b1;
                    state_next = (mem_done || timeout_hit) ? S_IDLE : S_DRAIN;
                end else if (mem_done) begin
                    push       = 1'b1;
                    state_next = S_IDLE;
                end else if (timeout_hit) begin
                    // IDLE re-issues the same PC after one cycle with mem_read low.
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (branch_valid) flush = 1'b1;
                if (mem_done || timeout_hit) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Program counter. Only a completed fetch advances it. A branch reloads it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 13'd0;
        end else if (flush) begin
            pc <= target_clamped;
        end else if (push) begin
            pc <= pc_inc;
        end
    end

    // Address of the request in flight. It is captured at issue so that it
    // survives a branch during DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr <= 13'd0;
        end else if (issue) begin
            req_addr <= pc;
        end
    end

    // Instruction buffer. A flush empties it. A simultaneous push and pop
    // leaves the occupancy unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= 13'd0;
                pc_q[i]   <= 13'd0;
            end
        end else if (flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= mem_dataOut;
                pc_q[wr_ptr]   <= pc;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign timeout_hit = (state != S_IDLE) && !mem_done && (to_cnt == TW'(TIMEOUT - 1));
    assign fetch_error = err_q;

    // Count cycles spent in WAIT/DRAIN. Restart on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == S_IDLE || state_next != state) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign fetch_error    = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with default parameters
// (PC_LIMIT=12, FIFO_DEPTH=2, TIMEOUT=15). Inputs change on the falling
// edge, and outputs are sampled on the falling edge.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [12:0] mem_address;
    logic        mem_read;
    logic        mem_instruction;
    logic [12:0] mem_dataOut;
    logic        mem_done;
    logic        branch_valid;
    logic [12:0] branch_target;
    logic [12:0] instr_out;
    logic [12:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_error;
    logic [1:0]  state_dbg;

    // memory model controls
    logic resp_done;
    logic force_done;
    logic resp_en;
    logic slow3;
    logic slow5;
    int   wcnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [12:0] req_q[$];
    logic [25:0] exp_q[$];
    logic        prev_read;

    assign mem_done = resp_done | force_done;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_instruction (mem_instruction),
        .mem_dataOut     (mem_dataOut),
        .mem_done        (mem_done),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .fetch_error     (fetch_error),
        .state_dbg       (state_dbg)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int resp_delay(input logic [12:0] a);
        if (a == 13'd3 && slow3) return 3;
        if (a == 13'd5 && slow5) return 1000;
        return 1;
    endfunction

    // memory responder: returns 13'h100+addr after the per-address delay
    initial begin
        resp_done   = 1'b0;
        mem_dataOut = 13'd0;
        wcnt        = 0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (reset && resp_en && mem_read) begin
                if (wcnt >= resp_delay(mem_address) - 1) begin
                    resp_done   = 1'b1;
                    mem_dataOut = 13'h100 + mem_address;
                    wcnt        = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // request log: one entry per rising edge of mem_read
    initial begin
        prev_read = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_read && !prev_read) req_q.push_back(mem_address);
            prev_read = mem_read;
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        branch_valid = 1'b0;
        repeat (2) @(negedge clk);
        req_q.delete();
        reset = 1'b1;
    endtask

    task automatic wait_req(input logic [12:0] a, input string tag);
        int n;
        n = 0;
        while (!(mem_read && mem_address == a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 100), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 100), 1);
    endtask

    function automatic logic [12:0] req_after(input logic [12:0] a);
        int idx;
        idx = -1;
        foreach (req_q[k]) if (req_q[k] == a) idx = k;
        if (idx >= 0 && idx + 1 < req_q.size()) return req_q[idx + 1];
        return 13'h1fff;
    endfunction

    initial begin
        int          got;
        int          cyc;
        logic [25:0] e;

        reset         = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 13'd0;
        instr_ready   = 1'b0;
        force_done    = 1'b0;
        resp_en       = 1'b0;
        slow3         = 1'b0;
        slow5         = 1'b0;

        // reset state
        #1 reset = 1'b0;
        #11;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_instr", mem_instruction, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_fetch_error", fetch_error, 0);
        check("rst_state", state_dbg, 0);
        @(negedge clk);

        // streaming fetch with wrap after PC_LIMIT
        for (int i = 0; i <= 12; i++) exp_q.push_back({13'h100 + 13'(i), 13'(i)});
        exp_q.push_back({13'h100, 13'd0});
        exp_q.push_back({13'h101, 13'd1});
        resp_en     = 1'b1;
        instr_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        check("t1_first_read", mem_read, 1);
        check("t1_first_instr", mem_instruction, 1);
        check("t1_first_addr", mem_address, 0);
        @(negedge clk);
        check("t1_latency_valid", instr_valid, 1);
        got = 0;
        cyc = 0;
        while (got < 15 && cyc < 300) begin
            if (instr_valid) begin
                e = exp_q.pop_front();
                check("t1_data", instr_out, e[25:13]);
                check("t1_pc", instr_pc, e[12:0]);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        check("t1_count", got, 15);

        // stalled consumer fills the buffer and stops requests
        instr_ready = 1'b0;
        apply_reset();
        repeat (10) @(negedge clk);
        check("t2_req_count", req_q.size(), 2);
        check("t2_req0", req_q[0], 0);
        check("t2_req1", req_q[1], 1);
        check("t2_read_idle", mem_read, 0);
        check("t2_head_data", instr_out, 13'h100);
        check("t2_head_pc", instr_pc, 0);
        repeat (3) @(negedge clk);
        check("t2_hold_data", instr_out, 13'h100);
        check("t2_hold_valid", instr_valid, 1);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("t2_pop_data", instr_out, 13'h101);
        check("t2_pop_pc", instr_pc, 1);
        repeat (8) @(negedge clk);
        check("t2_req_count2", req_q.size(), 3);
        check("t2_req2", req_q[2], 2);
        check("t2_read_idle2", mem_read, 0);

        // branch while WAIT on addr 3, response 3 cycles late
        slow3       = 1'b1;
        instr_ready = 1'b1;
        apply_reset();
        wait_req(13'd3, "t3_reach_addr3");
        branch_valid  = 1'b1;
        branch_target = 13'd7;
        @(negedge clk);
        branch_valid = 1'b0;
        check("t3_flush_valid", instr_valid, 0);
        check("t3_drain_state", state_dbg, 2);
        check("t3_drain_read", mem_read, 1);
        check("t3_drain_addr", mem_address, 3);
        wait_valid("t3_valid_seen");
        check("t3_first_pc", instr_pc, 7);
        check("t3_first_data", instr_out, 13'h107);
        check("t3_next_req", req_after(13'd3), 7);
        slow3 = 1'b0;

        // out-of-range target clamps to 0; branch together with mem_done
        apply_reset();
        wait_req(13'd4, "t4_reach_addr4");
        branch_valid  = 1'b1;
        branch_target = 13'd20;
        @(negedge clk);
        branch_valid = 1'b0;
        check("t4_flush_valid", instr_valid, 0);
        check("t4_idle_read", mem_read, 0);
        check("t4_idle_state", state_dbg, 0);
        wait_valid("t4_valid_seen");
        check("t4_first_pc", instr_pc, 0);
        check("t4_first_data", instr_out, 13'h100);
        check("t4_next_req", req_after(13'd4), 0);

        // memory never answers
        resp_en = 1'b0;
        apply_reset();
        @(negedge clk);
        check("t5_read_n1", mem_read, 1);
        check("t5_addr_n1", mem_address, 0);
        repeat (14) @(negedge clk);
        check("t5_read_n15", mem_read, 1);
        check("t5_err_n15", fetch_error, 0);
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        check("t5_read_gap", mem_read, 0);
        check("t5_err_set", fetch_error, 1);
        @(negedge clk);
        check("t5_reissue_read", mem_read, 1);
        check("t5_reissue_addr", mem_address, 0);
        check("t5_req_count", req_q.size(), 2);
`else
        check("t5_read_held", mem_read, 1);
        check("t5_err_low", fetch_error, 0);
        @(negedge clk);
        check("t5_read_held2", mem_read, 1);
        check("t5_addr_held", mem_address, 0);
        check("t5_req_count", req_q.size(), 1);
`endif

        // asynchronous reset mid-WAIT at addr 5, stray mem_done after release
        resp_en     = 1'b1;
        slow5       = 1'b1;
        instr_ready = 1'b1;
        apply_reset();
        wait_req(13'd5, "t6_reach_addr5");
        #2 reset = 1'b0;
        #1;
        check("t6_rst_read", mem_read, 0);
        check("t6_rst_instr", mem_instruction, 0);
        check("t6_rst_addr", mem_address, 0);
        check("t6_rst_valid", instr_valid, 0);
        check("t6_rst_out", instr_out, 0);
        check("t6_rst_pc", instr_pc, 0);
        check("t6_rst_err", fetch_error, 0);
        check("t6_rst_state", state_dbg, 0);
        @(negedge clk);
        resp_en    = 1'b0;
        slow5      = 1'b0;
        force_done = 1'b1;
        req_q.delete();
        reset      = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        check("t6_restart_read", mem_read, 1);
        check("t6_restart_addr", mem_address, 0);
        check("t6_stray_ignored", instr_valid, 0);
        check("t6_restart_state", state_dbg, 1);
        resp_en = 1'b1;
        wait_valid("t6_valid_seen");
        check("t6_first_pc", instr_pc, 0);
        check("t6_first_data", instr_out, 13'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
